// File: rtl/multi_alarm_clock.sv
// multi_alarm_clock
//   24-hour time-of-day clock with a cycle prescaler, N_ALARMS alarm slots and
//   a single-owner ring/snooze state machine.
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   switch              display mode: 0 = 24-hour, 1 = 12-hour with AM/PM
//   setTime/setHrs/setMin     load the time (out-of-range loads are ignored)
//   alarmWe/alarmSel/alarmHr/alarmMin/alarmEn   write one alarm slot
//   snooze, dismiss     user controls for the active alarm
//   hrs, min, AM, PM    registered display
//   ring, ringId        alarm sounding and the slot that owns it

// One alarm slot: stored time + enable, compared against the upcoming time.
module multi_alarm_clock_slot (
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [4:0] wr_hr,
  input  logic [5:0] wr_min,
  input  logic       wr_en,
  input  logic [4:0] cmp_hr,
  input  logic [5:0] cmp_min,
  output logic       match
);
  logic [4:0] hr_q;
  logic [5:0] min_q;
  logic       en_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hr_q  <= '0;
      min_q <= '0;
      en_q  <= 1'b0;
    end else if (we) begin
      hr_q  <= wr_hr;
      min_q <= wr_min;
      en_q  <= wr_en;
    end
  end

  assign match = en_q && (hr_q == cmp_hr) && (min_q == cmp_min);
endmodule

module multi_alarm_clock #(
  parameter int TICKS_PER_MIN = 60,
  parameter int N_ALARMS      = 4,
  parameter int SNOOZE_MIN    = 5,
  parameter int RING_MIN      = 1,
  parameter int SEL_W         = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             switch,
  input  logic             setTime,
  input  logic [4:0]       setHrs,
  input  logic [5:0]       setMin,
  input  logic             alarmWe,
  input  logic [SEL_W-1:0] alarmSel,
  input  logic [4:0]       alarmHr,
  input  logic [5:0]       alarmMin,
  input  logic             alarmEn,
  input  logic             snooze,
  input  logic             dismiss,
  output logic [4:0]       hrs,
  output logic [5:0]       min,
  output logic             AM,
  output logic             PM,
  output logic             ring,
  output logic [SEL_W-1:0] ringId
);
  localparam int PW = $clog2(TICKS_PER_MIN);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RING = 2'd1;
  localparam logic [1:0] S_SNZ  = 2'd2;

  logic [PW-1:0]       presc;
  logic [4:0]          hour_q, nxt_hr;
  logic [5:0]          min_q, nxt_min;
  logic                tick, set_ok, inc, wr_ok, kill;
  logic [N_ALARMS-1:0] match;
  logic                hit;
  logic [SEL_W-1:0]    hit_id;

  logic [1:0]          state, state_d;
  logic [5:0]          ring_cnt, ring_cnt_d, snz_cnt, snz_cnt_d;
  logic [SEL_W-1:0]    id, id_d;

  assign tick   = (presc == PW'(TICKS_PER_MIN - 1));
  assign set_ok = setTime && (setHrs <= 5'd23) && (setMin <= 6'd59);
  // A valid load takes the cycle; only then is the rollover lost.
  assign inc    = tick && !set_ok;
  assign wr_ok  = alarmWe && (32'(alarmSel) < 32'(N_ALARMS)) &&
                  (alarmHr <= 5'd23) && (alarmMin <= 6'd59);

  assign nxt_min = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
  assign nxt_hr  = (min_q != 6'd59) ? hour_q :
                   (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      presc  <= '0;
      hour_q <= '0;
      min_q  <= '0;
    end else if (set_ok) begin
      presc  <= '0;
      hour_q <= setHrs;
      min_q  <= setMin;
    end else if (tick) begin
      presc  <= '0;
      hour_q <= nxt_hr;
      min_q  <= nxt_min;
    end else begin
      presc  <= presc + PW'(1);
    end
  end

  // Slots compare against the time about to be entered, so a match lines up
  // with the minute increment that produces it.
  for (genvar i = 0; i < N_ALARMS; i++) begin : g_slot
    multi_alarm_clock_slot u_slot (
      .clk     (clk),
      .rst     (rst),
      .we      (wr_ok && (alarmSel == SEL_W'(i))),
      .wr_hr   (alarmHr),
      .wr_min  (alarmMin),
      .wr_en   (alarmEn),
      .cmp_hr  (nxt_hr),
      .cmp_min (nxt_min),
      .match   (match[i])
    );
  end

  // Lowest-index matching slot wins; scan downward so the last write sticks.
  always_comb begin
    hit    = 1'b0;
    hit_id = '0;
    for (int i = N_ALARMS - 1; i >= 0; i--) begin
      if (inc && match[i]) begin
        hit    = 1'b1;
        hit_id = SEL_W'(i);
      end
    end
  end

  // Reasons to abandon the active alarm: a valid time load, disabling the
  // owning slot, or dismiss (which also beats a same-cycle snooze).
  assign kill = set_ok || (wr_ok && (alarmSel == id) && !alarmEn) || dismiss;

  always_comb begin
    state_d    = state;
    ring_cnt_d = ring_cnt;
    snz_cnt_d  = snz_cnt;
    id_d       = id;
    case (state)
      S_IDLE: begin
        if (hit) begin
          state_d    = S_RING;
          id_d       = hit_id;
          ring_cnt_d = '0;
        end
      end
      S_RING: begin
        if (kill) begin
          state_d = S_IDLE;
        end else if (snooze) begin
          state_d   = S_SNZ;
          snz_cnt_d = '0;
        end else if (inc) begin
          if (ring_cnt == 6'(RING_MIN - 1)) state_d = S_IDLE;
          else ring_cnt_d = ring_cnt + 6'd1;
        end
      end
      S_SNZ: begin
        if (kill) begin
          state_d = S_IDLE;
        end else if (inc) begin
          if (snz_cnt == 6'(SNOOZE_MIN - 1)) begin
            state_d    = S_RING;
            ring_cnt_d = '0;
          end else begin
            snz_cnt_d = snz_cnt + 6'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      ring_cnt <= '0;
      snz_cnt  <= '0;
      id       <= '0;
      ring     <= 1'b0;
    end else begin
      state    <= state_d;
      ring_cnt <= ring_cnt_d;
      snz_cnt  <= snz_cnt_d;
      id       <= id_d;
      ring     <= (state_d == S_RING);
    end
  end

  assign ringId = id;

  // Display lags the internal time by one register stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      hrs <= '0;
      min <= '0;
      AM  <= 1'b0;
      PM  <= 1'b0;
    end else begin
      min <= min_q;
      if (switch) begin
        hrs <= (hour_q == 5'd0)  ? 5'd12 :
               (hour_q > 5'd12)  ? hour_q - 5'd12 : hour_q;
        AM  <= (hour_q < 5'd12);
        PM  <= (hour_q >= 5'd12);
      end else begin
        hrs <= hour_q;
        AM  <= 1'b0;
        PM  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_multi_alarm_clock.sv
// Testbench for multi_alarm_clock: directed scenarios followed by random
// stimulus, all outputs compared every cycle against a minute-count model.
module tb_multi_alarm_clock;
  localparam int TPM   = 4;
  localparam int NA    = 4;
  localparam int SNZM  = 2;
  localparam int RINGM = 3;

  localparam int M_IDLE = 0, M_RING = 1, M_SNZ = 2;

  logic       clk = 1'b0;
  logic       rst, switch, setTime, alarmWe, alarmEn, snooze, dismiss;
  logic [4:0] setHrs, alarmHr;
  logic [5:0] setMin, alarmMin;
  logic [1:0] alarmSel;
  logic [4:0] hrs;
  logic [5:0] min;
  logic       AM, PM, ring;
  logic [1:0] ringId;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: time as minutes since midnight
  int m_t, m_pre, m_st, m_rc, m_sc, m_id;
  int a_t [NA];
  bit a_en[NA];
  int e_hrs, e_min, e_am, e_pm, e_ring;

  multi_alarm_clock #(
    .TICKS_PER_MIN(TPM), .N_ALARMS(NA), .SNOOZE_MIN(SNZM), .RING_MIN(RINGM)
  ) dut (
    .clk(clk), .rst(rst), .switch(switch), .setTime(setTime),
    .setHrs(setHrs), .setMin(setMin), .alarmWe(alarmWe), .alarmSel(alarmSel),
    .alarmHr(alarmHr), .alarmMin(alarmMin), .alarmEn(alarmEn),
    .snooze(snooze), .dismiss(dismiss), .hrs(hrs), .min(min),
    .AM(AM), .PM(PM), .ring(ring), .ringId(ringId)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
  endtask

  task automatic model(input bit r, sw, st, input int sh, sm,
                       input bit we, input int sel, ah, am, input bit en, sz, ds);
    int h, newt, hit;
    bit set_ok, inc, wr_ok, kill;
    h = m_t / 60;
    if (r) begin
      e_hrs = 0; e_min = 0; e_am = 0; e_pm = 0;
    end else begin
      e_min = m_t % 60;
      if (sw) begin
        e_hrs = (h == 0) ? 12 : (h > 12 ? h - 12 : h);
        e_am  = (h < 12);
        e_pm  = (h >= 12);
      end else begin
        e_hrs = h; e_am = 0; e_pm = 0;
      end
    end
    set_ok = st && sh <= 23 && sm <= 59;
    inc    = !set_ok && m_pre == TPM - 1;
    wr_ok  = we && sel < NA && ah <= 23 && am <= 59;
    if (set_ok)   begin newt = sh * 60 + sm;    m_pre = 0; end
    else if (inc) begin newt = (m_t + 1) % 1440; m_pre = 0; end
    else          begin newt = m_t;             m_pre++;   end
    hit = -1;
    if (inc)
      for (int i = NA - 1; i >= 0; i--)
        if (a_en[i] && a_t[i] == newt) hit = i;
    kill = set_ok || (wr_ok && sel == m_id && !en) || ds;
    case (m_st)
      M_IDLE: if (hit >= 0) begin m_st = M_RING; m_id = hit; m_rc = 0; end
      M_RING: begin
        if (kill) m_st = M_IDLE;
        else if (sz) begin m_st = M_SNZ; m_sc = 0; end
        else if (inc) begin
          m_rc++;
          if (m_rc == RINGM) m_st = M_IDLE;
        end
      end
      default: begin
        if (kill) m_st = M_IDLE;
        else if (inc) begin
          m_sc++;
          if (m_sc == SNZM) begin m_st = M_RING; m_rc = 0; end
        end
      end
    endcase
    if (wr_ok) begin a_t[sel] = ah * 60 + am; a_en[sel] = en; end
    m_t = newt;
    if (r) begin
      m_t = 0; m_pre = 0; m_st = M_IDLE; m_id = 0; m_rc = 0; m_sc = 0;
      for (int i = 0; i < NA; i++) begin a_t[i] = 0; a_en[i] = 0; end
    end
    e_ring = (m_st == M_RING);
  endtask

  task automatic step(input bit r, sw, st, input int sh, sm,
                      input bit we, input int sel, ah, am, input bit en, sz, ds);
    rst = r; switch = sw; setTime = st; setHrs = 5'(sh); setMin = 6'(sm);
    alarmWe = we; alarmSel = 2'(sel); alarmHr = 5'(ah); alarmMin = 6'(am);
    alarmEn = en; snooze = sz; dismiss = ds;
    @(posedge clk);
    model(r, sw, st, sh, sm, we, sel, ah, am, en, sz, ds);
    #1;
    chk("hrs",    32'(hrs),    32'(e_hrs));
    chk("min",    32'(min),    32'(e_min));
    chk("AM",     32'(AM),     32'(e_am));
    chk("PM",     32'(PM),     32'(e_pm));
    chk("ring",   32'(ring),   32'(e_ring));
    chk("ringId", 32'(ringId), 32'(m_id));
  endtask

  // shorthands
  task automatic idle(input int n, input bit sw = 0);
    for (int i = 0; i < n; i++) step(0, sw, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic set_t(input int h, input int m, input bit sw = 0);
    step(0, sw, 1, h, m, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic wr_a(input int sel, input int h, input int m, input bit en);
    step(0, 0, 0, 0, 0, 1, sel, h, m, en, 0, 0);
  endtask

  initial begin
    bit r, sw, st, we, en, sz, ds;
    int sh, sm, sel, ah, am;

    // reset
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_hrs", 32'(hrs), 0);
    chk("rst_ring", 32'(ring), 0);
    chk("rst_id", 32'(ringId), 0);
    idle(1, 1);
    chk("rst_12h_hrs", 32'(hrs), 12);
    chk("rst_12h_am", 32'(AM), 1);

    // midnight rollover and 12-hour display
    set_t(23, 59);
    idle(4);
    idle(1, 1);
    chk("wrap_hrs", 32'(hrs), 12);
    chk("wrap_min", 32'(min), 0);
    chk("wrap_am", 32'(AM), 1);
    chk("wrap_pm", 32'(PM), 0);
    set_t(13, 25, 1);
    idle(1, 1);
    chk("pm_hrs", 32'(hrs), 1);
    chk("pm_pm", 32'(PM), 1);

    // two slots match at once: lowest wins
    wr_a(1, 7, 0, 1);
    wr_a(2, 7, 0, 1);
    set_t(6, 59);
    idle(4);
    chk("multi_ring", 32'(ring), 1);
    chk("multi_id", 32'(ringId), 1);

    // snooze, re-ring, auto stop
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("snz_ring", 32'(ring), 0);
    idle(8);
    chk("rering", 32'(ring), 1);
    idle(12);
    chk("autostop", 32'(ring), 0);

    // snooze + dismiss together
    set_t(6, 59);
    idle(4);
    chk("ring2", 32'(ring), 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    chk("dis_ring", 32'(ring), 0);
    idle(10);
    chk("dis_norering", 32'(ring), 0);

    // illegal loads ignored; loading onto the alarm time does not ring
    set_t(24, 10);
    set_t(10, 60);
    idle(3);
    set_t(7, 0);
    idle(5);
    chk("set_noring", 32'(ring), 0);

    // reset during snooze
    set_t(6, 59);
    idle(4);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(2);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_snz_ring", 32'(ring), 0);
    idle(10);
    chk("rst_snz_norering", 32'(ring), 0);
    set_t(6, 59);
    idle(5);
    chk("rst_slots_off", 32'(ring), 0);

    // random traffic around 10:00
    sw = 0;
    for (int n = 0; n < 2000; n++) begin
      r  = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 49) == 0) sw = ~sw;
      st = ($urandom_range(0, 39) == 0);
      sh = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 25) : 9 + $urandom_range(0, 1);
      sm = (sh == 9) ? 58 + $urandom_range(0, 1) : $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0) sm = 60;
      we = ($urandom_range(0, 19) == 0);
      sel = $urandom_range(0, NA - 1);
      ah = ($urandom_range(0, 7) == 0) ? 24 : 10;
      am = ($urandom_range(0, 9) == 0) ? 60 : $urandom_range(0, 8);
      en = ($urandom_range(0, 3) != 0);
      sz = ($urandom_range(0, 9) == 0);
      ds = ($urandom_range(0, 14) == 0);
      step(r, sw, st, sh, sm, we, sel, ah, am, en, sz, ds);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
